pipe_stage_hs: RTL and testbench

- Parametrised valid/ready pipeline stage that replaces fixed ID/EX-style bare registers between any two pipeline stages.
- Carries a control field and a data payload, with a full-throughput skid buffer for back-pressure.
- Flush converts the stage into a bubble, with all control bits zeroed so no regwrite/memwrite leaks.
- Instantiated at ID/EX, EX/MEM and MEM/WB with different widths.

---
 rtl/pipe_stage_hs.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_hs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage with a control field, a data
// payload and a one-entry skid buffer so back-pressure never needs a
// combinational ready path. A flush turns the stage into a bubble with all
// control bits cleared.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_hs #(
    parameter int CTRL_WIDTH = 10,
    parameter int DATA_WIDTH = 175,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_bubble_cnt,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q;
    logic                  valid_q;
    logic                  ready_q;
    logic [CTRL_WIDTH-1:0] main_ctrl_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q;
    logic [DATA_WIDTH-1:0] skid_data_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = i_valid & ready_q;
    assign out_fire = valid_q & i_ready;

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_ctrl  = main_ctrl_q;
    assign o_data  = main_data_q;

    // Handshake FSM; main control is cleared whenever the stage goes empty so
    // a bubble never carries live control bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (i_flush) begin
            state_q     <= EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= BUSY;
                        valid_q     <= 1'b1;
                        main_ctrl_q <= i_ctrl;
                        main_data_q <= i_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_q <= i_ctrl;
                        main_data_q <= i_data;
                    end else if (in_fire) begin
                        state_q     <= FULL;
                        ready_q     <= 1'b0;
                        skid_ctrl_q <= i_ctrl;
                        skid_data_q <= i_data;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        valid_q     <= 1'b0;
                        main_ctrl_q <= '0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_q     <= BUSY;
                        ready_q     <= 1'b1;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    valid_q     <= 1'b0;
                    ready_q     <= 1'b1;
                    main_ctrl_q <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_WIDTH-1:0] bubble_cnt_q;
    logic [CNT_WIDTH-1:0] bubble_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    // Saturating next values for the bubble and stall counters.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!valid_q && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end
        if (valid_q && !i_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers; cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
    assign o_stall_cnt  = stall_cnt_q;
`else
    assign o_bubble_cnt = '0;
    assign o_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed, table-driven bench for pipe_stage_hs, plus
// hand-written sequences for asynchronous reset and the statistics counters.
module tb_pipe_stage_hs;

    localparam int CW = 10;
    localparam int DW = 175;
    localparam int NW = 16;

    logic          clk;
    logic          rstN;
    logic          inValid;
    logic          outReady;
    logic [CW-1:0] inCtrl;
    logic [DW-1:0] inData;
    logic          flush;
    logic          outValid;
    logic          dnReady;
    logic [CW-1:0] outCtrl;
    logic [DW-1:0] outData;
    logic [NW-1:0] bubbleCnt;
    logic [NW-1:0] stallCnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_hs #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_valid      (inValid),
        .o_ready      (outReady),
        .i_ctrl       (inCtrl),
        .i_data       (inData),
        .i_flush      (flush),
        .o_valid      (outValid),
        .i_ready      (dnReady),
        .o_ctrl       (outCtrl),
        .o_data       (outData),
        .o_bubble_cnt (bubbleCnt),
        .o_stall_cnt  (stallCnt)
    );

`ifdef PIPE_STAGE_STATS_EN
    logic          smallReady;
    logic          smallValid;
    logic [CW-1:0] smallCtrl;
    logic [DW-1:0] smallData;
    logic [1:0]    smallBubble;
    logic [1:0]    smallStall;

    pipe_stage_hs #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dutSmall (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_valid      (inValid),
        .o_ready      (smallReady),
        .i_ctrl       (inCtrl),
        .i_data       (inData),
        .i_flush      (flush),
        .o_valid      (smallValid),
        .i_ready      (dnReady),
        .o_ctrl       (smallCtrl),
        .o_data       (smallData),
        .o_bubble_cnt (smallBubble),
        .o_stall_cnt  (smallStall)
    );
`endif

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          ready;
        logic          flush;
        logic          expValid;
        logic          expReady;
        logic [CW-1:0] expCtrl;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t vecs[32];
    int   nVecs = 0;

    // Append one {inputs, expected outputs after the next edge} record
    task automatic addVec(input logic v, input logic [CW-1:0] c, input int d,
                          input logic r, input logic f, input logic ev,
                          input logic er, input logic [CW-1:0] ec, input int ed);
        vecs[nVecs].valid    = v;
        vecs[nVecs].ctrl     = c;
        vecs[nVecs].data     = DW'(d);
        vecs[nVecs].ready    = r;
        vecs[nVecs].flush    = f;
        vecs[nVecs].expValid = ev;
        vecs[nVecs].expReady = er;
        vecs[nVecs].expCtrl  = ec;
        vecs[nVecs].expData  = DW'(ed);
        nVecs++;
    endtask

    // Generic single-value comparison
    task automatic checkValue(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare all handshake outputs against expectations
    task automatic checkOutput(input string tag, input logic ev, input logic er,
                               input logic [CW-1:0] ec, input logic [DW-1:0] ed);
        checkValue({tag, ".o_valid"}, DW'(outValid), DW'(ev));
        checkValue({tag, ".o_ready"}, DW'(outReady), DW'(er));
        checkValue({tag, ".o_ctrl"},  DW'(outCtrl),  DW'(ec));
        checkValue({tag, ".o_data"},  outData,       ed);
    endtask

    // Drive one cycle of inputs, clock it in, sample 1 ns after the edge
    task automatic applyStimulus(input logic v, input logic [CW-1:0] c,
                                 input logic [DW-1:0] d, input logic r,
                                 input logic f);
        inValid = v;
        inCtrl  = c;
        inData  = d;
        dnReady = r;
        flush   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // First accept with all control bits set
        addVec(1, 10'h3FF, 1, 1, 0,  1, 1, 10'h3FF, 1);
        // Full-rate stream 2..8, then drain
        for (int k = 2; k <= 8; k++) addVec(1, CW'(k), k, 1, 0,  1, 1, CW'(k), k);
        addVec(0, 0, 0, 1, 0,  0, 1, 0, 8);
        // Back-pressure: stream 1..4, i_ready low for 3 cycles
        addVec(1, 1, 1, 1, 0,  1, 1, 1, 1);
        addVec(1, 2, 2, 0, 0,  1, 0, 1, 1);
        addVec(1, 3, 3, 0, 0,  1, 0, 1, 1);
        addVec(1, 3, 3, 0, 0,  1, 0, 1, 1);
        addVec(1, 3, 3, 1, 0,  1, 1, 2, 2);
        addVec(1, 3, 3, 1, 0,  1, 1, 3, 3);
        addVec(1, 4, 4, 1, 0,  1, 1, 4, 4);
        addVec(0, 0, 0, 1, 0,  0, 1, 0, 4);
        // Flush from FULL with data 9 offered
        addVec(1, 5, 5, 0, 0,  1, 1, 5, 5);
        addVec(1, 6, 6, 0, 0,  1, 0, 5, 5);
        addVec(1, 10'h3FF, 9, 0, 1,  0, 1, 0, 5);
        // Flush from BUSY with a simultaneous accept and drain
        addVec(1, 7, 7, 1, 0,  1, 1, 7, 7);
        addVec(1, 10'h3FF, 9, 1, 1,  0, 1, 0, 7);
        addVec(0, 0, 0, 1, 0,  0, 1, 0, 7);

        rstN    = 1'b0;
        inValid = 1'b0;
        inCtrl  = '0;
        inData  = '0;
        dnReady = 1'b1;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 0, 1, 0, 0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < nVecs; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].ctrl, vecs[i].data,
                          vecs[i].ready, vecs[i].flush);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid,
                        vecs[i].expReady, vecs[i].expCtrl, vecs[i].expData);
        end

`ifndef PIPE_STAGE_STATS_EN
        checkValue("bubbleTied", DW'(bubbleCnt), '0);
        checkValue("stallTied",  DW'(stallCnt),  '0);
`endif

        // Asynchronous reset between clock edges while the stage holds data
        applyStimulus(1, 10'h2AA, DW'(10), 1, 0);
        checkOutput("preAsync", 1, 1, 10'h2AA, DW'(10));
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset", 0, 1, 0, 0);

        // Idle and stall accounting from a fresh reset
        inValid = 1'b0;
        dnReady = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(1, 3, DW'(11), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, 0);
        checkOutput("stallHold", 1, 1, 3, DW'(11));
`ifdef PIPE_STAGE_STATS_EN
        checkValue("bubbleCnt", DW'(bubbleCnt), DW'(5));
        checkValue("stallCnt",  DW'(stallCnt),  DW'(3));
        applyStimulus(0, 0, '0, 0, 0);
        checkValue("stallCnt4",   DW'(stallCnt),    DW'(4));
        checkValue("bubbleSat",   DW'(smallBubble), DW'(3));
        checkValue("stallSat",    DW'(smallStall),  DW'(3));
`else
        checkValue("bubbleTied2", DW'(bubbleCnt), '0);
        checkValue("stallTied2",  DW'(stallCnt),  '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
